// File: rtl/udp_payload_buffer_if.sv
// -----------------------------------------------------------------------------
// udp_payload_buffer_if
//
// Handshake and status bundle between the acquisition source / UDP frame
// transmitter (master side) and the ping-pong payload buffer (slave side).
//
// Signals:
//   i_data       [15:0] acquisition word
//   i_valid             i_data valid this cycle
//   o_enable            frame trigger, falling edge starts a frame
//   o_udp_len    [15:0] payload byte count of the pending frame
//   o_udp_stream [7:0]  current payload byte (first-word-fall-through)
//   i_udp_rd            transmitter consumed o_udp_stream
//   o_overflow          sticky: a word was dropped
//   o_drop_cnt   [15:0] saturating dropped-word count
//   o_busy              read side not idle
// -----------------------------------------------------------------------------
interface udp_payload_buffer_if;
  logic [15:0] i_data;
  logic        i_valid;
  logic        o_enable;
  logic [15:0] o_udp_len;
  logic [7:0]  o_udp_stream;
  logic        i_udp_rd;
  logic        o_overflow;
  logic [15:0] o_drop_cnt;
  logic        o_busy;

  modport master (
    output i_data, i_valid, i_udp_rd,
    input  o_enable, o_udp_len, o_udp_stream, o_overflow, o_drop_cnt, o_busy
  );

  modport slave (
    input  i_data, i_valid, i_udp_rd,
    output o_enable, o_udp_len, o_udp_stream, o_overflow, o_drop_cnt, o_busy
  );
endinterface

// File: rtl/udp_payload_buffer.sv
// -----------------------------------------------------------------------------
// udp_payload_buffer
//
// Ping-pong payload buffer feeding a UDP frame transmitter. 16-bit words fill
// one bank while the other bank is served byte-wise (high byte first). A full
// bank raises o_enable for two cycles; the falling edge starts the frame. After
// the last byte is read the bank is released and a gap of GAP_CYCLES clocks is
// enforced before the next trigger.
//
// Parameters:
//   PKT_WORDS   payload words per frame (2..1024)
//   GAP_CYCLES  minimum clocks from last payload read to next trigger (1..65535)
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    udp_payload_buffer_if.slave (data in, transmitter handshake, status)
//
// Build option:
//   UDP_PAYLOAD_SEQNUM_EN  when defined, each frame is prefixed with a 16-bit
//                          sequence number (high byte first) and o_udp_len
//                          grows by 2.
// -----------------------------------------------------------------------------
module udp_payload_buffer #(
  parameter int PKT_WORDS  = 8,
  parameter int GAP_CYCLES = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  udp_payload_buffer_if.slave  bus
);

  localparam int AW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
`ifdef UDP_PAYLOAD_SEQNUM_EN
  localparam int HDR_BYTES = 2;
`else
  localparam int HDR_BYTES = 0;
`endif
  localparam int FRAME_BYTES = 2 * PKT_WORDS + HDR_BYTES;
  localparam int RBW         = $clog2(2 * PKT_WORDS + 2);

  localparam logic [15:0]    UDP_LEN    = 16'(FRAME_BYTES);
  localparam logic [AW-1:0]  LAST_WADDR = AW'(PKT_WORDS - 1);
  localparam logic [RBW-1:0] LAST_RBYTE = RBW'(FRAME_BYTES - 1);
  localparam logic [RBW-1:0] HDR_OFFS   = RBW'(HDR_BYTES);
  localparam logic [15:0]    GAP_LOAD   = 16'(GAP_CYCLES);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG_HI = 3'd1;
  localparam logic [2:0] ST_TRIG_LO = 3'd2;
  localparam logic [2:0] ST_SERVE   = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  // Bank storage
  logic [15:0] mem [2][PKT_WORDS];

  // Write side
  logic          wbank;
  logic [AW-1:0] waddr;
  logic [1:0]    full;
  logic          wr_accept;
  logic          wr_drop;
  logic          overflow;
  logic [15:0]   drop_cnt;

  // Read side
  logic [2:0]     state;
  logic           rbank;
  logic [RBW-1:0] rbyte;
  logic           trig_cnt;
  logic [15:0]    gap_cnt;
  logic [15:0]    udp_len;
  logic           enable;
  logic           release_bank;

  // Output datapath
  logic [RBW-1:0] data_byte;
  logic [AW-1:0]  rd_word;
  logic [15:0]    rd_data;
  logic [7:0]     stream;

  assign wr_accept    = bus.i_valid && !full[wbank];
  assign wr_drop      = bus.i_valid &&  full[wbank];
  assign release_bank = (state == ST_SERVE) && bus.i_udp_rd && (rbyte == LAST_RBYTE);

  // NOTE: the payload RAM carries no reset; its contents are only ever read
  // after being written, and a reset port would block RAM inference.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wbank][waddr] <= bus.i_data;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank <= 1'b0;
      waddr <= '0;
    end else if (wr_accept) begin
      if (waddr == LAST_WADDR) begin
        waddr <= '0;
        wbank <= ~wbank;
      end else begin
        waddr <= waddr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      if (wr_accept && (waddr == LAST_WADDR)) begin
        full[wbank] <= 1'b1;
      end
      // Placed last so a release overrides any same-cycle set on that bank.
      if (release_bank) begin
        full[rbank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= 16'h0000;
    end else if (wr_drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Read-side FSM. o_enable is registered from the state, so it lags the
  // state by one clock: rises one cycle after entering TRIG_HI and falls on
  // the edge that enters SERVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rbank    <= 1'b0;
      rbyte    <= '0;
      trig_cnt <= 1'b0;
      gap_cnt  <= 16'h0000;
      udp_len  <= 16'h0000;
      enable   <= 1'b0;
    end else begin
      enable <= (state == ST_TRIG_HI);
      case (state)
        ST_IDLE: begin
          if (full[rbank]) begin
            udp_len  <= UDP_LEN;
            trig_cnt <= 1'b0;
            state    <= ST_TRIG_HI;
          end
        end
        ST_TRIG_HI: begin
          if (trig_cnt) begin
            state <= ST_TRIG_LO;
          end else begin
            trig_cnt <= 1'b1;
          end
        end
        ST_TRIG_LO: begin
          rbyte <= '0;
          state <= ST_SERVE;
        end
        ST_SERVE: begin
          if (bus.i_udp_rd) begin
            if (rbyte == LAST_RBYTE) begin
              rbyte   <= '0;
              rbank   <= ~rbank;
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end else begin
              rbyte <= rbyte + RBW'(1);
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 16'd1;
          if (gap_cnt == 16'd1) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef UDP_PAYLOAD_SEQNUM_EN
  logic [15:0] seq_num;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_num <= 16'h0000;
    end else if (release_bank) begin
      seq_num <= seq_num + 16'd1;
    end
  end
`endif

  // NOTE: every signal driven here gets a default first so no latch is
  // inferred on any path through the if/else chain.
  always_comb begin
    stream    = 8'h00;
    data_byte = rbyte - HDR_OFFS;
    rd_word   = AW'(data_byte >> 1);
    rd_data   = mem[rbank][rd_word];
    if (state == ST_SERVE) begin
`ifdef UDP_PAYLOAD_SEQNUM_EN
      if (rbyte == RBW'(0)) begin
        stream = seq_num[15:8];
      end else if (rbyte == RBW'(1)) begin
        stream = seq_num[7:0];
      end else begin
        stream = data_byte[0] ? rd_data[7:0] : rd_data[15:8];
      end
`else
      stream = data_byte[0] ? rd_data[7:0] : rd_data[15:8];
`endif
    end
  end

  assign bus.o_enable     = enable;
  assign bus.o_udp_len    = udp_len;
  assign bus.o_udp_stream = stream;
  assign bus.o_overflow   = overflow;
  assign bus.o_drop_cnt   = drop_cnt;
  assign bus.o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_udp_payload_buffer.sv
// -----------------------------------------------------------------------------
// tb_udp_payload_buffer
//
// Self-checking bench for udp_payload_buffer (PKT_WORDS=8, GAP_CYCLES=128).
// Directed table for the first frame's cycle-exact timing, hand-written
// sequences for overflow and mid-frame reset, and a randomized stream checked
// against a queue-based model of the accepted words.
// -----------------------------------------------------------------------------
module tb_udp_payload_buffer;

  localparam int P   = 8;
  localparam int GAP = 128;
`ifdef UDP_PAYLOAD_SEQNUM_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int LEN = 2 * P + HDR;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  udp_payload_buffer_if bus();

  udp_payload_buffer #(
    .PKT_WORDS  (P),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] bench_seq = 16'h0000;
  logic [7:0]  fb [LEN];

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        rd;
    logic        exp_en;
    logic [7:0]  exp_stream;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic r,
                              input logic en, input logic [7:0] s, input logic b);
    vec_t t;
    t.valid = v; t.data = d; t.rd = r; t.exp_en = en; t.exp_stream = s; t.exp_busy = b;
    return t;
  endfunction

  // Byte j of the table frame: sequence 0 prefix, then data bytes 01,02,...
  function automatic logic [7:0] tbyte(input int j);
    if (j < HDR) return 8'h00;
    return 8'(j - HDR + 1);
  endfunction

  // Expected frame = sequence prefix + next P accepted words, high byte first.
  task automatic load_frame();
    logic [15:0] w;
    for (int j = 0; j < HDR; j++) fb[j] = (j == 0) ? bench_seq[15:8] : bench_seq[7:0];
    for (int k = 0; k < P; k++) begin
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
      fb[HDR + 2*k]     = w[15:8];
      fb[HDR + 2*k + 1] = w[7:0];
    end
  endtask

  task automatic reset_dut();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_enable", bus.o_enable, 0);
    check("rst_async_busy", bus.o_busy, 0);
    check("rst_async_stream", bus.o_udp_stream, 0);
    bus.i_valid  = 1'b0;
    bus.i_udp_rd = 1'b0;
    bus.i_data   = 16'h0000;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("reset_enable", bus.o_enable, 0);
    check("reset_len", bus.o_udp_len, 0);
    check("reset_stream", bus.o_udp_stream, 0);
    check("reset_overflow", bus.o_overflow, 0);
    check("reset_drop_cnt", bus.o_drop_cnt, 0);
    check("reset_busy", bus.o_busy, 0);
    exp_q.delete();
    bench_seq = 16'h0000;
  endtask

  task automatic write_word(input logic [15:0] w, input bit accept);
    bus.i_valid = 1'b1;
    bus.i_data  = w;
    tick();
    bus.i_valid = 1'b0;
    if (accept) exp_q.push_back(w);
  endtask

  task automatic wait_fall(input int budget);
    logic prev;
    int   hi   = 0;
    bit   rise = 0;
    bit   done = 0;
    prev = bus.o_enable;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      if (!prev && bus.o_enable) begin rise = 1; hi = 0; end
      if (bus.o_enable) hi++;
      if (prev && !bus.o_enable) begin
        done = 1;
        if (rise) check("enable_width", hi, 2);
      end
      prev = bus.o_enable;
    end
    check("fall_seen", 32'(done), 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget && bus.o_busy; c++) tick();
    check("idle_seen", bus.o_busy, 0);
  endtask

  // Serve n bytes of the current frame; a full frame releases the bank.
  task automatic read_frame(input int n);
    check("frame_len", bus.o_udp_len, LEN);
    check("frame_busy", bus.o_busy, 1);
    load_frame();
    for (int j = 0; j < n; j++) begin
      check($sformatf("frame_byte%0d", j), bus.o_udp_stream, fb[j]);
      bus.i_udp_rd = 1'b1;
      tick();
      bus.i_udp_rd = 1'b0;
    end
    if (n == LEN) begin
      check("frame_stream_after", bus.o_udp_stream, 0);
      bench_seq++;
    end
  endtask

  // Randomized stream: writer only offers a word when the model says a bank
  // slot is free (two payloads of capacity, freed one clock after the final
  // read), so nothing should ever be dropped.
  task automatic run_stream(input int n_words, input int wr_pct, input int rd_pct, input int budget);
    int   written = 0, frames = 0, in_buf = 0, bi = 0, hi = 0, c = 0, last_rd = 0;
    int   nfr = n_words / P;
    bit   serving = 0, rel_pending = 0, have_last = 0;
    logic prev_en = 1'b0;
    logic [15:0] w;
    while (frames < nfr && c < budget) begin
      tick();
      c++;
      if (rel_pending) begin
        in_buf -= P;
        frames++;
        last_rd = c;
        have_last = 1;
        rel_pending = 0;
      end
      if (!prev_en && bus.o_enable) begin
        hi = 0;
        check("stream_len", bus.o_udp_len, LEN);
        if (have_last) check("stream_gap_ok", 32'(c - last_rd >= GAP), 1);
      end
      if (bus.o_enable) hi++;
      if (prev_en && !bus.o_enable) begin
        check("stream_enable_width", hi, 2);
        load_frame();
        serving = 1;
        bi = 0;
      end
      prev_en = bus.o_enable;
      if (serving) begin
        check($sformatf("stream_byte%0d", bi), bus.o_udp_stream, fb[bi]);
        check("stream_busy", bus.o_busy, 1);
      end else begin
        check("stream_idle_zero", bus.o_udp_stream, 0);
      end
      bus.i_udp_rd = 1'b0;
      if (serving) begin
        if ($urandom_range(99) < rd_pct) begin
          bus.i_udp_rd = 1'b1;
          bi++;
          if (bi == LEN) begin
            serving = 0;
            rel_pending = 1;
            bench_seq++;
          end
        end
      end else begin
        bus.i_udp_rd = ($urandom_range(99) < 30);
      end
      bus.i_valid = 1'b0;
      if (written < n_words && in_buf < 2 * P && $urandom_range(99) < wr_pct) begin
        w = 16'($urandom);
        bus.i_valid = 1'b1;
        bus.i_data  = w;
        exp_q.push_back(w);
        written++;
        in_buf++;
      end
    end
    if (rel_pending) begin
      tick();
      frames++;
    end
    bus.i_valid  = 1'b0;
    bus.i_udp_rd = 1'b0;
    check("stream_frames_done", frames, nfr);
    check("stream_no_drop", bus.o_drop_cnt, 0);
    check("stream_no_overflow", bus.o_overflow, 0);
    wait_idle(400);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid  = 1'b0;
    bus.i_udp_rd = 1'b0;
    bus.i_data   = 16'h0000;

    // Directed single-frame table (timing relative to the 8th write edge).
    for (int k = 0; k < P; k++)
      tbl.push_back(mk(1'b1, 16'(((2*k + 1) << 8) | (2*k + 2)), (k < 3), 1'b0, 8'h00, 1'b0));
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 1'b0, 8'h00, 1'b1));       // N+1: TRIG_HI
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 8'h00, 1'b1));       // N+2: enable rises
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 8'h00, 1'b1));       // N+3
    tbl.push_back(mk(1'b0, 16'h0, 1'b1, 1'b0, tbyte(0), 1'b1));    // N+4: fall, SERVE
    for (int j = 0; j < LEN; j++)
      tbl.push_back(mk(1'b0, 16'h0, 1'b1, 1'b0, (j == LEN - 1) ? 8'h00 : tbyte(j + 1), 1'b1));
    for (int j = 0; j < 3; j++)
      tbl.push_back(mk(1'b0, 16'h0, 1'b1, 1'b0, 8'h00, 1'b1));     // spurious reads in GAP

    reset_dut();

    foreach (tbl[i]) begin
      bus.i_valid  = tbl[i].valid;
      bus.i_data   = tbl[i].data;
      bus.i_udp_rd = tbl[i].rd;
      tick();
      check($sformatf("tbl%0d_enable", i), bus.o_enable, tbl[i].exp_en);
      check($sformatf("tbl%0d_stream", i), bus.o_udp_stream, tbl[i].exp_stream);
      check($sformatf("tbl%0d_busy", i), bus.o_busy, tbl[i].exp_busy);
    end
    bus.i_valid  = 1'b0;
    bus.i_udp_rd = 1'b0;
    check("tbl_len", bus.o_udp_len, LEN);
    bench_seq++;
    wait_idle(400);

    // Ping-pong: three frames with a free-running writer and reader.
    run_stream(3 * P, 100, 100, 3000);

    // Randomized traffic.
    run_stream(6 * P, 40, 60, 8000);

    // Overflow: both banks full, three words dropped, then bank 0 reused.
    reset_dut();
    for (int k = 0; k < P; k++) write_word(16'($urandom), 1'b1);
    wait_fall(50);
    for (int k = 0; k < P; k++) write_word(16'($urandom), 1'b1);
    for (int k = 0; k < 3; k++) write_word(16'($urandom), 1'b0);
    check("ovf_flag", bus.o_overflow, 1);
    check("ovf_drop_cnt", bus.o_drop_cnt, 3);
    read_frame(LEN);
    write_word(16'hABCD, 1'b1);
    wait_fall(400);
    read_frame(LEN);
    for (int k = 0; k < P - 1; k++) write_word(16'($urandom), 1'b1);
    wait_fall(400);
    check("ovf_first_byte_bank0", bus.o_udp_stream, (HDR > 0) ? 32'(bench_seq[15:8]) : 32'hAB);
    read_frame(LEN);
    check("ovf_drop_cnt_final", bus.o_drop_cnt, 3);
    check("ovf_flag_sticky", bus.o_overflow, 1);
    wait_idle(400);

    // Reset mid-SERVE, then a fresh frame must start from sequence 0.
    reset_dut();
    for (int k = 0; k < P; k++) write_word(16'($urandom), 1'b1);
    wait_fall(50);
    read_frame(5);
    reset_dut();
    for (int k = 0; k < P; k++) write_word(16'($urandom), 1'b1);
    wait_fall(50);
    read_frame(LEN);
    wait_idle(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
